// File: rtl/menu_jogo_pkg.sv
// menu_jogo_pkg: state codes, screen codes and button indices shared by the menu controller
package menu_jogo_pkg;
    localparam logic [4:0] INICIAL     = 5'd0;
    localparam logic [4:0] RESET_JOGO  = 5'd1;
    localparam logic [4:0] MENU_RENDER = 5'd2;
    localparam logic [4:0] MENU_ENVIA  = 5'd3;
    localparam logic [4:0] MENU_ESPERA = 5'd4;
    localparam logic [4:0] MENU_NAVEGA = 5'd5;
    localparam logic [4:0] INICIA_JOGO = 5'd6;
    localparam logic [4:0] JOGANDO     = 5'd7;
    localparam logic [4:0] FIM_RENDER  = 5'd8;
    localparam logic [4:0] FIM_ENVIA   = 5'd9;
    localparam logic [4:0] FIM_ESPERA  = 5'd10;
    localparam logic [7:0] TELA_MENU_BASE = 8'h10;
    localparam logic [7:0] TELA_JOGO      = 8'h01;
    localparam logic [7:0] TELA_FIM       = 8'h02;
    localparam int BTN_UP       = 5;
    localparam int BTN_DOWN     = 4;
    localparam int BTN_LEFT     = 3;
    localparam int BTN_RIGHT    = 2;
    localparam int BTN_ESPECIAL = 1;
    localparam int BTN_TIRO     = 0;
endpackage

// File: rtl/menu_jogo_n_filtro_borda.sv
// filtro_borda: debounces one raw button and emits a one-cycle pulse on the filtered rising edge
module filtro_borda
    import menu_jogo_pkg::*;
#(
    parameter int ESTAVEL_CICLOS = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic entrada,
    output logic nivel,
    output logic pulso
);
    localparam int CW = $clog2(ESTAVEL_CICLOS + 1);
    localparam logic [CW-1:0] LIM = CW'(ESTAVEL_CICLOS - 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic nivel_q, nivel_d, anterior_q, anterior_d, pulso_q, pulso_d;
    // count consecutive disagreeing samples; the level flips only when the run is long enough
    always_comb begin
        cnt_d      = (entrada == nivel_q || cnt_q == LIM) ? '0 : cnt_q + 1'b1;
        nivel_d    = (entrada != nivel_q && cnt_q == LIM) ? entrada : nivel_q;
        anterior_d = nivel_q;
        pulso_d    = nivel_q & ~anterior_q;
    end
    // state registers, cleared by the active-low synchronous reset
    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt_q      <= '0;
            nivel_q    <= 1'b0;
            anterior_q <= 1'b0;
            pulso_q    <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            nivel_q    <= nivel_d;
            anterior_q <= anterior_d;
            pulso_q    <= pulso_d;
        end
    end
    assign nivel = nivel_q;
    assign pulso = pulso_q;
endmodule

// File: rtl/menu_jogo_n.sv
// menu_jogo_n: game menu controller sequencing screen transmission, cursor navigation and game start/end
module menu_jogo_n
    import menu_jogo_pkg::*;
#(
    parameter int N_CHAVES       = 6,
    parameter int N_OPCOES       = 4,
    parameter int ESTAVEL_CICLOS = 4,
    parameter int TELA_W         = 8
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [N_CHAVES-1:0]         chaves,
    input  logic                        pronto,
    input  logic                        fim_envia_dados,
    output logic                        envia_dados,
    output logic                        iniciar,
    output logic                        reset_jogo_base,
    output logic                        jogo_base_em_andamento,
    output logic [$clog2(N_OPCOES)-1:0] opcao,
    output logic                        selecionou,
    output logic [TELA_W-1:0]           tela_renderizada,
    output logic [N_CHAVES-1:0]         jogada,
    output logic [4:0]                  db_estado
);
    localparam int OW = $clog2(N_OPCOES);
    localparam logic [OW-1:0] ULTIMA = OW'(N_OPCOES - 1);
    logic [N_CHAVES-1:0] nivel, pulso, jogada_q, jogada_d;
    logic [4:0] estado_q, estado_d;
    logic [OW-1:0] opcao_q, opcao_d;
    logic fim_visto_q, fim_visto_d;
    logic cima, baixo, tiro, pulsos_unused;

    for (genvar i = 0; i < N_CHAVES; i++) begin : g_filtro
        filtro_borda #(.ESTAVEL_CICLOS(ESTAVEL_CICLOS)) u_filtro (
            .clock  (clock),
            .reset  (reset),
            .entrada(chaves[i]),
            .nivel  (nivel[i]),
            .pulso  (pulso[i])
        );
    end

    assign cima          = pulso[BTN_UP];
    assign baixo         = pulso[BTN_DOWN];
    assign tiro          = pulso[BTN_TIRO];
    assign pulsos_unused = ^pulso;

    // next state; press pulses only matter in MENU_NAVEGA and FIM_ESPERA, tiro beats up/down
    always_comb begin
        estado_d    = estado_q;
        opcao_d     = opcao_q;
        fim_visto_d = (estado_q == FIM_ESPERA) && (fim_visto_q || fim_envia_dados);
        jogada_d    = (estado_q == JOGANDO) ? nivel : '0;
        case (estado_q)
            INICIAL:     estado_d = RESET_JOGO;
            RESET_JOGO:  estado_d = MENU_RENDER;
            MENU_RENDER: estado_d = MENU_ENVIA;
            MENU_ENVIA:  estado_d = MENU_ESPERA;
            MENU_ESPERA: estado_d = fim_envia_dados ? MENU_NAVEGA : MENU_ESPERA;
            MENU_NAVEGA: begin
                if (tiro) begin
                    estado_d = (opcao_q == '0) ? INICIA_JOGO : MENU_RENDER;
                end else if (cima != baixo) begin
                    opcao_d  = cima ? ((opcao_q == '0) ? ULTIMA : opcao_q - 1'b1)
                                    : ((opcao_q == ULTIMA) ? '0 : opcao_q + 1'b1);
                    estado_d = MENU_RENDER;
                end
            end
            INICIA_JOGO: estado_d = JOGANDO;
            JOGANDO:     estado_d = pronto ? FIM_RENDER : JOGANDO;
            FIM_RENDER:  estado_d = FIM_ENVIA;
            FIM_ENVIA:   estado_d = FIM_ESPERA;
            FIM_ESPERA: begin
                if (fim_visto_q && tiro) begin
                    estado_d = RESET_JOGO;
                    opcao_d  = '0;
                end
            end
            default:     estado_d = INICIAL;
        endcase
    end

    // state registers, cleared by the active-low synchronous reset
    always_ff @(posedge clock) begin
        if (!reset) begin
            estado_q    <= INICIAL;
            opcao_q     <= '0;
            jogada_q    <= '0;
            fim_visto_q <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            opcao_q     <= opcao_d;
            jogada_q    <= jogada_d;
            fim_visto_q <= fim_visto_d;
        end
    end

    // screen code selected by the current phase; menu screens are offset by the cursor
    always_comb begin
        tela_renderizada = (estado_q inside {MENU_RENDER, MENU_ENVIA, MENU_ESPERA, MENU_NAVEGA})
                         ? TELA_W'(TELA_MENU_BASE) + TELA_W'(opcao_q)
                         : (estado_q inside {INICIA_JOGO, JOGANDO}) ? TELA_W'(TELA_JOGO)
                         : (estado_q inside {FIM_RENDER, FIM_ENVIA, FIM_ESPERA}) ? TELA_W'(TELA_FIM)
                         : '0;
    end

    assign envia_dados            = (estado_q == MENU_ENVIA) || (estado_q == FIM_ENVIA);
    assign iniciar                = (estado_q == INICIA_JOGO);
    assign reset_jogo_base        = (estado_q == RESET_JOGO);
    assign jogo_base_em_andamento = (estado_q == JOGANDO);
    assign selecionou             = (estado_q == MENU_NAVEGA) && tiro && (opcao_q != '0);
    assign opcao                  = opcao_q;
    assign jogada                 = jogada_q;
    assign db_estado              = estado_q;
endmodule

// File: tb/tb_menu_jogo_n.sv
// tb_menu_jogo_n: table-driven menu navigation plus hand-written game/reset sequences with a screen scoreboard
module tb_menu_jogo_n;
    import menu_jogo_pkg::*;

    logic clock = 1'b0, reset = 1'b0, pronto = 1'b0, fim_envia_dados = 1'b0;
    logic [5:0] chaves = '0;
    logic envia_dados, iniciar, reset_jogo_base, jogo_base_em_andamento, selecionou;
    logic [1:0] opcao;
    logic [7:0] tela_renderizada;
    logic [5:0] jogada;
    logic [4:0] db_estado;

    int n_cmp = 0, n_err = 0;
    int cnt_sel = 0, cnt_ini = 0, cnt_env = 0, cnt_rst = 0;
    logic [7:0] sb_tela[$];
    bit auto_fim = 1'b1;

    typedef struct {
        logic [5:0] chaves;
        int         hold;
        logic [1:0] opcao;
        int         envios;
        int         sels;
    } vet_t;
    vet_t v[12];

    always #5 clock = ~clock;

    menu_jogo_n dut (
        .clock                 (clock),
        .reset                 (reset),
        .chaves                (chaves),
        .pronto                (pronto),
        .fim_envia_dados       (fim_envia_dados),
        .envia_dados           (envia_dados),
        .iniciar               (iniciar),
        .reset_jogo_base       (reset_jogo_base),
        .jogo_base_em_andamento(jogo_base_em_andamento),
        .opcao                 (opcao),
        .selecionou            (selecionou),
        .tela_renderizada      (tela_renderizada),
        .jogada                (jogada),
        .db_estado             (db_estado)
    );

    task automatic check(input string nome, input logic [31:0] atual, input logic [31:0] esp);
        n_cmp++;
        if (atual !== esp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nome, atual, esp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        cnt_sel += int'(selecionou);
        cnt_ini += int'(iniciar);
        cnt_env += int'(envia_dados);
        cnt_rst += int'(reset_jogo_base);
    endtask

    task automatic ciclos(input int n);
        repeat (n) tick();
    endtask

    task automatic zera();
        cnt_sel = 0;
        cnt_ini = 0;
        cnt_env = 0;
        cnt_rst = 0;
    endtask

    task automatic aperta(input logic [5:0] m, input int n);
        chaves = m;
        ciclos(n);
        chaves = '0;
    endtask

    task automatic espera_estado(input logic [4:0] s, input int max, input string nome);
        for (int i = 0; i < max && db_estado !== s; i++) tick();
        check(nome, 32'(db_estado), 32'(s));
    endtask

    task automatic saidas_zero(input string nome);
        check(nome, 32'({envia_dados, iniciar, reset_jogo_base, jogo_base_em_andamento,
                         selecionou, opcao, tela_renderizada, jogada}), 32'd0);
        check({nome, " estado"}, 32'(db_estado), 32'(INICIAL));
    endtask

    // every transmitted screen must match the next expected one queued by the stimulus
    initial forever begin
        logic [7:0] e;
        @(posedge clock);
        #1;
        if (envia_dados === 1'b1) begin
            e = (sb_tela.size() != 0) ? sb_tela.pop_front() : 8'hxx;
            check("tela enviada", 32'(tela_renderizada), 32'(e));
        end
    end

    // transmitter model: completes each transmission while the FSM is waiting for it
    initial forever begin
        @(posedge clock);
        #1;
        if (auto_fim && envia_dados === 1'b1) begin
            @(posedge clock);
            #1;
            fim_envia_dados = 1'b1;
            @(posedge clock);
            #1;
            fim_envia_dados = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        v[0]  = '{6'h10, 3, 2'd0, 0, 0};
        v[1]  = '{6'h10, 6, 2'd1, 1, 0};
        v[2]  = '{6'h20, 6, 2'd0, 1, 0};
        v[3]  = '{6'h20, 6, 2'd3, 1, 0};
        v[4]  = '{6'h10, 6, 2'd0, 1, 0};
        v[5]  = '{6'h30, 6, 2'd0, 0, 0};
        v[6]  = '{6'h0E, 6, 2'd0, 0, 0};
        v[7]  = '{6'h10, 6, 2'd1, 1, 0};
        v[8]  = '{6'h10, 6, 2'd2, 1, 0};
        v[9]  = '{6'h11, 6, 2'd2, 1, 1};
        v[10] = '{6'h20, 6, 2'd1, 1, 0};
        v[11] = '{6'h20, 6, 2'd0, 1, 0};

        ciclos(3);
        saidas_zero("reset inicial");
        sb_tela.push_back(8'h10);
        reset = 1'b1;
        tick();
        check("boot reset_jogo_base c2", 32'(reset_jogo_base), 32'd1);
        tick();
        check("boot estado c3", 32'(db_estado), 32'(MENU_RENDER));
        tick();
        check("boot envia c4", 32'(envia_dados), 32'd1);
        check("boot tela c4", 32'(tela_renderizada), 32'h10);
        espera_estado(MENU_NAVEGA, 10, "boot navega");

        pronto = 1'b1;
        ciclos(3);
        pronto = 1'b0;
        check("pronto no menu", 32'(db_estado), 32'(MENU_NAVEGA));

        for (int i = 0; i < 12; i++) begin
            zera();
            if (v[i].envios != 0) sb_tela.push_back(8'(8'h10 + 8'(v[i].opcao)));
            aperta(v[i].chaves, v[i].hold);
            ciclos(20);
            check($sformatf("vet%0d opcao", i), 32'(opcao), 32'(v[i].opcao));
            check($sformatf("vet%0d envios", i), 32'(cnt_env), 32'(v[i].envios));
            check($sformatf("vet%0d selecionou", i), 32'(cnt_sel), 32'(v[i].sels));
            check($sformatf("vet%0d estado", i), 32'(db_estado), 32'(MENU_NAVEGA));
        end

        zera();
        aperta(6'h01, 6);
        espera_estado(JOGANDO, 20, "inicia jogando");
        check("iniciar pulsos", 32'(cnt_ini), 32'd1);
        check("sem selecionou", 32'(cnt_sel), 32'd0);
        check("em andamento", 32'(jogo_base_em_andamento), 32'd1);
        check("tela jogo", 32'(tela_renderizada), 32'h01);
        chaves = 6'h24;
        ciclos(6);
        check("jogada 24", 32'(jogada), 32'h24);
        chaves = 6'h04;
        ciclos(6);
        check("jogada 04", 32'(jogada), 32'h04);

        zera();
        sb_tela.push_back(8'h02);
        pronto = 1'b1;
        tick();
        pronto = 1'b0;
        check("fim render", 32'(db_estado), 32'(FIM_RENDER));
        check("fim tela", 32'(tela_renderizada), 32'h02);
        check("fim fora do jogo", 32'(jogo_base_em_andamento), 32'd0);
        check("jogada ultimo jogando", 32'(jogada), 32'h04);
        tick();
        check("jogada zerada", 32'(jogada), 32'h00);
        check("fim envia", 32'(envia_dados), 32'd1);
        chaves = '0;
        espera_estado(FIM_ESPERA, 10, "fim espera");
        ciclos(4);
        check("fim espera parado", 32'(db_estado), 32'(FIM_ESPERA));
        zera();
        sb_tela.push_back(8'h10);
        aperta(6'h01, 6);
        espera_estado(MENU_NAVEGA, 30, "volta ao menu");
        check("reset_jogo_base pulsos", 32'(cnt_rst), 32'd1);
        check("opcao apos fim", 32'(opcao), 32'd0);

        auto_fim = 1'b0;
        sb_tela.push_back(8'h11);
        aperta(6'h10, 6);
        espera_estado(MENU_ESPERA, 20, "menu espera");
        aperta(6'h20, 6);
        ciclos(6);
        check("espera segura", 32'(db_estado), 32'(MENU_ESPERA));
        check("up descartado", 32'(opcao), 32'd1);
        reset = 1'b0;
        tick();
        saidas_zero("reset em espera");
        reset = 1'b1;
        auto_fim = 1'b1;
        sb_tela.push_back(8'h10);
        espera_estado(MENU_NAVEGA, 20, "reboot 1");

        aperta(6'h01, 6);
        espera_estado(JOGANDO, 20, "jogo 2");
        chaves = 6'h20;
        ciclos(8);
        check("jogada 20", 32'(jogada), 32'h20);
        reset = 1'b0;
        tick();
        saidas_zero("reset em jogo");
        chaves = '0;
        reset = 1'b1;
        sb_tela.push_back(8'h10);
        espera_estado(MENU_NAVEGA, 20, "reboot 2");
        ciclos(2);
        check("fila de telas vazia", 32'(sb_tela.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
